// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_e : receiver FSM states (IDLE, START, DATA, STOP)
//   OVERSAMPLE : sub-bit ticks per bit
//   SAMPLE_IDX : sub-bit index of the mid-bit sample
//   OS_W       : width of the sub-bit counter
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_IDX = 7;
    localparam int OS_W       = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator shared by the UART RX and TX paths. Counts
// 0..div_i-1 and pulses tick_o for one cycle on the terminal count.
// A divisor of 0 behaves as 1 (tick every cycle).
// Ports:
//   clk, rst_n : clock, asynchronous active-high reset
//   clr_i      : synchronous clear; restarts the count at 0, no tick
//   div_i      : clocks per tick
//   tick_o     : one-cycle tick
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] term;

    always_comb begin
        term   = (div_i == '0) ? '0 : div_i - 1'b1;
        // ">=" keeps the counter from running past the terminal value
        // when the divisor shrinks mid-count.
        tick_o = !clr_i && (cnt_q >= term);
        cnt_d  = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART serial receive front-end: synchronises rx_i, detects start bits,
// 16x-oversamples each bit and deserialises LSB-first frames
// (1 start, DATA_WIDTH data, 1 stop, no parity).
// Optional feature: define UART_RX_MAJORITY_EN to decide each bit by a
// 2-of-3 vote of the samples at sub-bit 6, 7 and 8 (decision at 8).
// Ports:
//   clk, rst_n   : clock, asynchronous active-high reset
//   baud_div_i   : clocks per oversample tick
//   rx_en_i      : receiver enable; low forces IDLE and drops any frame
//   rx_i         : asynchronous serial line, idle high
//   fifo_full_i  : RX FIFO full
//   data_o       : received byte, valid while push_o is high
//   push_o       : one-cycle FIFO write strobe
//   frame_err_o  : one-cycle pulse, stop bit sampled low
//   overrun_o    : one-cycle pulse, good frame dropped (FIFO full)
//   busy_o       : FSM not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_i,
    input  logic                  fifo_full_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  push_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  sync1_q, sync2_q, hist_q;
    logic                  start_edge;
    logic                  tick, tick_clr;
    logic                  sample_pt, bit_val;
    rx_state_e             state_q, state_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  push_q, push_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tick_clr),
        .div_i  (baud_div_i),
        .tick_o (tick)
    );

    // Two-flop synchroniser plus a history flop; all reset to the idle level.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Only a genuine 1->0 transition starts a frame, so a held-low line
    // cannot re-trigger after a framing error.
    assign start_edge = hist_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_EN
    logic vote6_q, vote7_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vote6_q <= 1'b1;
            vote7_q <= 1'b1;
        end else if (tick) begin
            if (os_cnt_q == OS_W'(SAMPLE_IDX - 1)) vote6_q <= sync2_q;
            if (os_cnt_q == OS_W'(SAMPLE_IDX))     vote7_q <= sync2_q;
        end
    end

    // Third vote is the live sample at sub-bit 8.
    assign sample_pt = tick && (os_cnt_q == OS_W'(SAMPLE_IDX + 1));
    assign bit_val   = (vote6_q & vote7_q) | (vote6_q & sync2_q) | (vote7_q & sync2_q);
`else
    assign sample_pt = tick && (os_cnt_q == OS_W'(SAMPLE_IDX));
    assign bit_val   = sync2_q;
`endif

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        tick_clr  = 1'b0;

        // Wraps 15 -> 0 naturally at each bit boundary.
        if (tick) begin
            os_cnt_d = os_cnt_q + 1'b1;
        end

        if (!rx_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d  = START;
                        os_cnt_d = '0;
                        tick_clr = 1'b1;
                    end
                end
                START: begin
                    bit_cnt_d = '0;
                    if (sample_pt) begin
                        state_d = bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (sample_pt) begin
                        state_d = IDLE;
                        if (!bit_val) begin
                            ferr_d = 1'b1;
                        end else if (fifo_full_i) begin
                            ovr_d = 1'b1;
                        end else begin
                            push_d = 1'b1;
                            data_d = shift_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign push_o      = push_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx at baud_div = 4 (64 clocks per bit). Frames are built
// bit by bit; the expected outcome of each frame (push / frame error /
// overrun) is derived from the frame content and the FIFO-full level and
// queued in exp_q. A monitor compares every output pulse against that queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW      = 8;
  localparam int DIVW    = 16;
  localparam int BIT_CYC = 64;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_ADD = 4;
`else
  localparam int MAJ_ADD = 0;
`endif

  localparam logic [2:0] EV_PUSH = 3'b100;
  localparam logic [2:0] EV_FE   = 3'b010;
  localparam logic [2:0] EV_OVR  = 3'b001;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DIVW-1:0] baud_div_i;
  logic            rx_en_i;
  logic            rx_i;
  logic            fifo_full_i;
  logic [DW-1:0]   data_o;
  logic            push_o;
  logic            frame_err_o;
  logic            overrun_o;
  logic            busy_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div_i  (baud_div_i),
    .rx_en_i     (rx_en_i),
    .rx_i        (rx_i),
    .fifo_full_i (fifo_full_i),
    .data_o      (data_o),
    .push_o      (push_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int fe_cnt   = 0;
  int ovr_cnt  = 0;
  int last_push_cyc = 0;
  logic [DW-1:0] last_push_data = '0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] got_ev;
    logic [10:0] want_ev;
    if (!rst_n) begin
      if (push_o || frame_err_o || overrun_o) begin
        got_ev = {push_o, frame_err_o, overrun_o, (push_o ? data_o : 8'h00)};
        if (push_o) begin
          push_cnt++;
          last_push_cyc  = cyc;
          last_push_data = data_o;
        end
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ovr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(got_ev), 32'd0);
        end else begin
          want_ev = exp_q.pop_front();
          check("event", 32'(got_ev), 32'(want_ev));
        end
      end
      if (!rx_en_i) begin
        check("disabled_quiet", 32'({push_o, frame_err_o, overrun_o}), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Optional glitch inverts the line for one clock at the bit centre.
  task automatic send_bit(input logic v, input bit glitch);
    rx_i = v;
    if (glitch) begin
      cyc_wait(BIT_CYC / 2);
      rx_i = ~v;
      cyc_wait(1);
      rx_i = v;
      cyc_wait(BIT_CYC / 2 - 1);
    end else begin
      cyc_wait(BIT_CYC);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input bit glitch,
                            input bit expect_ev);
    if (expect_ev) begin
      if (!stop)            exp_q.push_back({EV_FE, 8'h00});
      else if (fifo_full_i) exp_q.push_back({EV_OVR, 8'h00});
      else                  exp_q.push_back({EV_PUSH, d});
    end
    start_cyc = cyc;
    send_bit(1'b0, glitch);
    for (int i = 0; i < DW; i++) send_bit(d[i], glitch);
    send_bit(stop, glitch);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      cyc_wait(1);
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, f0, o0, lat, fall;
    bit seen_busy;
    logic [DW-1:0] d;

    rx_i        = 1'b1;
    rx_en_i     = 1'b0;
    fifo_full_i = 1'b0;
    baud_div_i  = 16'd4;
    rst_n       = 1'b1;
    cyc_wait(5);
    check("rst_push", 32'(push_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst_n = 1'b0;
    cyc_wait(3);
    rx_en_i = 1'b1;
    cyc_wait(5);

    // Clean frame
    p0 = push_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    drain("clean");
    lat = last_push_cyc - start_cyc;
    check("clean_push_count", push_cnt - p0, 32'd1);
    check("clean_data", 32'(last_push_data), 32'hA5);
    check("clean_flags", (fe_cnt - f0) + (ovr_cnt - o0), 32'd0);
    check("clean_latency", 32'(lat >= 607 + MAJ_ADD && lat <= 615 + MAJ_ADD), 32'd1);
    cyc_wait(20);

    // Glitch rejection: 20-cycle low pulse
    p0 = push_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    seen_busy = 1'b0;
    fall = -1;
    for (int i = 0; i < 60; i++) begin
      rx_i = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy_o) seen_busy = 1'b1;
      else if (seen_busy && fall < 0) fall = i;
      @(posedge clk);
      #1;
    end
    check("glitch_busy_seen", 32'(seen_busy), 32'd1);
    check("glitch_busy_fall_lt40", 32'(fall >= 0 && fall < 40), 32'd1);
    check("glitch_no_events", (push_cnt - p0) + (fe_cnt - f0) + (ovr_cnt - o0), 32'd0);
    cyc_wait(20);

    // Framing error, then a break held for 3 frame-times
    p0 = push_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    rx_i = 1'b0;
    cyc_wait(3 * 10 * BIT_CYC);
    rx_i = 1'b1;
    cyc_wait(40);
    drain("frame_err");
    check("ferr_count", fe_cnt - f0, 32'd1);
    check("ferr_no_push", push_cnt - p0, 32'd0);

    // Overrun, then a normal frame
    p0 = push_cnt; o0 = ovr_cnt;
    fifo_full_i = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    drain("overrun");
    fifo_full_i = 1'b0;
    check("ovr_count", ovr_cnt - o0, 32'd1);
    check("ovr_no_push", push_cnt - p0, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    drain("after_ovr");
    check("after_ovr_data", 32'(last_push_data), 32'h7E);
    cyc_wait(20);

    // Disable during data bit 3 of 0xFF
    p0 = push_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        cyc_wait(BIT_CYC * 4 + 20);
        check("disable_busy_before", 32'(busy_o), 32'd1);
        rx_en_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("disable_idle", 32'(busy_o), 32'd0);
      end
    join
    cyc_wait(10);
    rx_en_i = 1'b1;
    cyc_wait(5);
    check("disable_no_events", (push_cnt - p0) + (fe_cnt - f0) + (ovr_cnt - o0), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b1);
    drain("reenable");
    check("reenable_data", 32'(last_push_data), 32'h12);
    cyc_wait(20);

    // Back-to-back random frames
    p0 = push_cnt;
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom_range(0, 255));
      send_frame(d, 1'b1, 1'b0, 1'b1);
    end
    drain("b2b");
    check("b2b_count", push_cnt - p0, 32'd16);
    cyc_wait(20);

`ifdef UART_RX_MAJORITY_EN
    // Back-to-back with a one-clock glitch at the centre of every bit
    p0 = push_cnt;
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom_range(0, 255));
      send_frame(d, 1'b1, 1'b1, 1'b1);
    end
    drain("b2b_glitch");
    check("b2b_glitch_count", push_cnt - p0, 32'd16);
    cyc_wait(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front-end of the UART: synchronises the `uart_rx` pin, detects start bits, 16x-oversamples each bit, and deserialises LSB-first frames (1 start, DATA_WIDTH data, 1 stop, no parity). Each good byte is pushed into the UART's RX FIFO. Framing errors and FIFO overruns are flagged to the status register logic. It sits between the pad and the RX FIFO, and is driven by the divisor held in the UART baud register.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset rst_n, asynchronous, active-high; clock clk.
- `baud_div_i`  in  DIV_WIDTH  clocks per oversample tick (clk_freq / (16 × baud)).
- `rx_en_i`  in  1  receiver enable (CTRL register bit 1).
- `rx_i`  in  1  asynchronous serial line; idle high.
- `fifo_full_i`  in  1  RX FIFO full.
- `data_o`  out  DATA_WIDTH  received byte; valid only while `push_o` is high.
- `push_o`  out  1  single-cycle RX FIFO write strobe.
- `frame_err_o`  out  1  single-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  single-cycle pulse: good frame dropped because the FIFO was full.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- **Reset values:** all outputs are 0. The synchroniser flops reset to 1. The FSM resets to IDLE. The tick counter and the bit counter reset to 0.
- **Synchroniser:** 2-flop synchroniser on `rx_i`, plus one history flop used for edge detection.
- **Tick generator:** counts 0..`baud_div_i`−1 and emits a 1-cycle `tick` on the terminal count.
  - `baud_div_i` = 0 behaves as 1, i.e. a tick every cycle.
  - The counter is cleared on start-bit detection, so phase is aligned to each frame.
- **Sub-bit counter `os_cnt`:** counts 0..15 and advances on each tick. It wraps from 15 to 0 at a bit boundary.
- **IDLE:** waits for a synced 1→0 transition. On detection it clears `os_cnt` and the tick counter, then enters START.
- **START:** at the sample point, a low sample enters DATA. A high sample is a glitch: return to IDLE, no flag.
- **DATA:** at each sample point, shift the sample into bit[DATA_WIDTH−1] of a right-shift register (LSB-first). After DATA_WIDTH samples, enter STOP.
- **STOP:** at the sample point:
  - Sample = 1 and FIFO not full: pulse `push_o` with `data_o` = shift register.
  - Sample = 1 and `fifo_full_i` = 1: pulse `overrun_o`; no push.
  - Sample = 0: pulse `frame_err_o`; no push; the byte is discarded.
  - In every case, return to IDLE.
- **Re-arming after a frame error:** IDLE requires a fresh 1→0 edge. A held-low (break) line therefore produces exactly one `frame_err_o` and no further frames.
- **Disable:** `rx_en_i` = 0 forces IDLE within 1 cycle, discards any partial frame, and raises no flag. While disabled, `push_o`, `frame_err_o` and `overrun_o` stay 0.
- **Divisor change mid-frame:** takes effect on the next tick-counter reload. Frame integrity is not guaranteed.

## Timing
- Sample point = tick with `os_cnt` = 7, i.e. mid-bit (see Configuration for the majority-vote variant).
- `push_o`, `frame_err_o` and `overrun_o` are registered. Each asserts 1 cycle after the stop-bit sample tick and lasts exactly 1 cycle.
- Edge to flag, nominal: 2 cycles (synchroniser) + 9.5 bit-times + 1 cycle, where bit-time = 16 × `baud_div_i`.
- A new start edge is accepted from the cycle after STOP exits. Back-to-back frames with one stop bit are received without loss.
- `fifo_full_i` is sampled in the same cycle as the stop-bit decision.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each bit (start, data, stop) is the 2-of-3 majority of samples at `os_cnt` = 6, 7, 8. The decision is made at `os_cnt` = 8, so all flags are 1 tick later than without the macro.
- **Not defined:** a single sample at `os_cnt` = 7 decides each bit. The vote registers are not present.

## Structure
- `uart_pkg` holds:
  - `rx_state_e` {IDLE, START, DATA, STOP};
  - `OVERSAMPLE` = 16;
  - `SAMPLE_IDX` = 7.
- `uart_baud_tick` is a sub-module: divisor counter with sync clear, outputting `tick`. It is shared with the TX serialiser.
- The synchroniser, FSM, shift register and flag logic stay in `uart_rx`.

## Test plan
All scenarios use `baud_div_i` = 4, so 1 bit = 64 cycles.
- **Clean frame:** drive 0xA5 frame → exactly one `push_o` with `data_o` = 0xA5, about 610 cycles after the start edge; no error flags.
- **Glitch rejection:** a 20-cycle low pulse on an idle line → no `push_o`, no flags; `busy_o` returns to 0 before cycle 40.
- **Framing error:** frame 0x3C with stop bit driven low → one `frame_err_o` pulse and no push. Holding the line low for 3 frame-times produces no further pulses.
- **Overrun:** `fifo_full_i` = 1 during frame 0x81 → one `overrun_o` pulse; `push_o` stays 0. Frame 0x7E with `fifo_full_i` = 0 → push 0x7E.
- **Disable mid-frame:** drop `rx_en_i` during data bit 3 of 0xFF → no push, no flags, IDLE next cycle. Re-enable, then send 0x12 → push 0x12.
- **Back-to-back, both builds:** 16 random frames sent with no gap, with and without `UART_RX_MAJORITY_EN` → all 16 bytes pushed in order, matching a reference queue. With the macro, a 1-cycle glitch at `os_cnt` = 7 of every bit leaves the data uncorrupted.
